// File: rtl/gpu_pkg.sv
// Shared widths, defaults and the fetch state encoding for the instruction fetch path.
package gpu_pkg;

  localparam int INSTR_W        = 32;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: one entry per fetched word, tagged with its address.
// Push into a full buffer and pop from an empty one are both dropped.
module fetch_fifo
  import gpu_pkg::*;
#(
  parameter int WIDTH = INSTR_W + DEF_ADDR_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observable while the entry is occupied.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: walks a program's word addresses, reads them from
// instruction memory one request at a time, and hands them to the decoder in order.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; a zero-length program only pulses done
//   ST_FETCH | issuing reads while the buffer has room, until count is met
//   ST_DRAIN | all words fetched; waiting for the decoder to empty buffer
module inst_fetch_unit
  import gpu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic [ADDR_W-1:0]  prog_len,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done
);

  localparam int ENTRY_W = INSTR_W + ADDR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e        state;
  fetch_state_e        state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   remaining;
  logic                zero_done;
  logic                load;
  logic                ack_taken;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  head;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and control outputs. mem_req only depends on buffer space, and
  // only the fetch itself can fill the buffer, so a raised request cannot drop
  // before its ack.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    busy      = 1'b0;
    done      = zero_done;
    load      = 1'b0;
    ack_taken = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (prog_len != '0) state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy      = 1'b1;
        mem_req   = !fifo_full;
        ack_taken = mem_req && mem_ack;
        if (ack_taken && remaining == ADDR_W'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (fifo_count == '0) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Program counter and remaining-word down-counter; an empty program is
  // flagged so done pulses in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      remaining <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= load && (prog_len == '0);
      if (load) begin
        pc        <= start_pc;
        remaining <= prog_len;
      end else if (ack_taken) begin
        pc        <= pc + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  assign mem_addr    = pc;
  assign instr_valid = !fifo_empty;
  assign fifo_pop    = instr_valid && instr_ready;
  assign instruction = instr_valid ? head[ENTRY_W-1:ADDR_W] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0]       : '0;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ack_taken),
    .push_data ({mem_rdata, pc}),
    .pop       (fifo_pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a random-latency memory responder, a
// random-ready decoder, and a monitor that checks deliveries against the queue
// of expected (pc, word) pairs filled when each program is launched.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_pc;
  logic [7:0]  prog_len;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;
  logic        done;

  int tests    = 0;
  int failures = 0;

  logic [31:0] imem [256];

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  int ready_mode = 1;
  int delay_min  = 0;
  int delay_max  = 0;
  bit spurious   = 1'b0;
  bit rst_window = 1'b1;
  int ack_count  = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_pc    (start_pc),
    .prog_len    (prog_len),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected program contents come straight from the address sequence.
  task automatic launch(input logic [7:0] pc, input logic [7:0] len);
    exp_t e;
    logic [7:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a     = pc + 8'(i);
      e.pc  = a;
      e.ins = imem[a];
      exp_q.push_back(e);
    end
    start    = 1'b1;
    start_pc = pc;
    prog_len = len;
    @(posedge clk);
    #1;
    start    = 1'b0;
    start_pc = 8'($urandom);
    prog_len = 8'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      @(negedge clk);
      if (done) got = 1'b1;
      n++;
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    chk({name, "_all_delivered"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_mem_req"},     64'(mem_req),     64'd0);
    chk({name, "_mem_addr"},    64'(mem_addr),    64'd0);
    chk({name, "_instruction"}, 64'(instruction), 64'd0);
    chk({name, "_instr_pc"},    64'(instr_pc),    64'd0);
    chk({name, "_instr_valid"}, 64'(instr_valid), 64'd0);
    chk({name, "_busy"},        64'(busy),        64'd0);
    chk({name, "_done"},        64'(done),        64'd0);
  endtask

  // Memory responder: acks each request after a random wait and checks the
  // request holds still while it waits.
  initial begin : responder
    bit         waiting;
    int         wait_left;
    logic [7:0] req_addr;
    waiting   = 1'b0;
    wait_left = 0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!waiting) begin
          waiting   = 1'b1;
          req_addr  = mem_addr;
          wait_left = int'($urandom_range(delay_max, delay_min));
        end else begin
          chk("req_addr_stable", 64'(mem_addr), 64'(req_addr));
        end
        if (wait_left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = imem[mem_addr];
          waiting   = 1'b0;
          ack_count++;
        end else begin
          wait_left--;
        end
      end else begin
        if (waiting && !rst_window) chk("req_held_until_ack", 64'(mem_req), 64'd1);
        waiting = 1'b0;
        if (spurious) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Decoder-side ready generator.
  initial begin : ready_gen
    instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       instr_ready = 1'b0;
        1:       instr_ready = 1'b1;
        default: instr_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops and compares on each handshake; checks stalled outputs hold.
  initial begin : monitor
    bit          stall;
    logic [31:0] s_ins;
    logic [7:0]  s_pc;
    exp_t        e;
    stall = 1'b0;
    s_ins = '0;
    s_pc  = '0;
    forever begin
      @(negedge clk);
      if (done) done_count++;
      if (stall && !rst_window) begin
        chk("hold_valid", 64'(instr_valid), 64'd1);
        chk("hold_instr", 64'(instruction), 64'(s_ins));
        chk("hold_pc",    64'(instr_pc),    64'(s_pc));
      end
      stall = instr_valid && !instr_ready;
      s_ins = instruction;
      s_pc  = instr_pc;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_delivery_queue", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc",    64'(instr_pc),    64'(e.pc));
          chk("deliver_instr", 64'(instruction), 64'(e.ins));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dc;
    logic [7:0] rpc;
    logic [7:0] rlen;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    reset    = 1'b1;
    start    = 1'b0;
    start_pc = '0;
    prog_len = '0;
    cyc(3);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk);
    #1;
    reset      = 1'b0;
    rst_window = 1'b0;
    cyc(2);

    // Latency and one-per-cycle throughput with zero-wait memory.
    ready_mode = 1;
    delay_min  = 0;
    delay_max  = 0;
    cyc(2);
    launch(8'h10, 8'd3);
    @(negedge clk);
    chk("lat_mem_req",  64'(mem_req),  64'd1);
    chk("lat_mem_addr", 64'(mem_addr), 64'h10);
    chk("lat_busy",     64'(busy),     64'd1);
    @(negedge clk);
    chk("lat_valid0", 64'(instr_valid), 64'd1);
    chk("lat_pc0",    64'(instr_pc),    64'h10);
    @(negedge clk);
    chk("lat_pc1", 64'(instr_pc), 64'h11);
    @(negedge clk);
    chk("lat_pc2", 64'(instr_pc), 64'h12);
    @(negedge clk);
    chk("lat_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("lat_done_pulse", 64'(done), 64'd0);
    chk("lat_busy_end",   64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_all_delivered", 64'(exp_q.size()), 64'd0);

    // Back-pressure: buffer fills, fetch stops, stray acks are ignored.
    ready_mode = 0;
    cyc(2);
    ack_count = 0;
    launch(8'h40, 8'd6);
    cyc(8);
    spurious = 1'b1;
    cyc(3);
    spurious = 1'b0;
    @(negedge clk);
    chk("bp_acks_when_full", 64'(ack_count), 64'd4);
    chk("bp_mem_req_off",    64'(mem_req),   64'd0);
    chk("bp_valid",          64'(instr_valid), 64'd1);
    chk("bp_busy",           64'(busy),      64'd1);
    @(posedge clk);
    #1;
    ready_mode = 1;
    wait_done("bp", 200);
    chk("bp_total_acks", 64'(ack_count), 64'd6);

    // Slow memory, then stray acks while idle.
    delay_min = 3;
    delay_max = 3;
    launch(8'h80, 8'd4);
    wait_done("slow", 200);
    dc = done_count;
    spurious = 1'b1;
    cyc(4);
    spurious = 1'b0;
    @(negedge clk);
    chk("idle_ack_valid", 64'(instr_valid), 64'd0);
    chk("idle_ack_busy",  64'(busy),        64'd0);
    chk("idle_ack_req",   64'(mem_req),     64'd0);
    chk("idle_ack_done",  64'(done_count),  64'(dc));
    @(posedge clk);
    #1;

    // Address wrap.
    delay_min  = 0;
    delay_max  = 2;
    ready_mode = 2;
    launch(8'hFE, 8'd3);
    wait_done("wrap", 300);

    // Empty program.
    dc = done_count;
    launch(8'h33, 8'd0);
    @(negedge clk);
    chk("empty_done",    64'(done),    64'd1);
    chk("empty_busy",    64'(busy),    64'd0);
    chk("empty_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    chk("empty_done_pulse", 64'(done),       64'd0);
    chk("empty_done_count", 64'(done_count), 64'(dc + 1));
    @(posedge clk);
    #1;

    // Reset while a request is outstanding, with a late ack just after.
    delay_min  = 3;
    delay_max  = 3;
    ready_mode = 1;
    launch(8'h20, 8'd8);
    cyc(2);
    rst_window = 1'b1;
    spurious   = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    exp_q.delete();
    cyc(2);
    spurious = 1'b0;
    cyc(2);
    chk("postreset_valid", 64'(instr_valid), 64'd0);
    chk("postreset_busy",  64'(busy),        64'd0);
    rst_window = 1'b0;
    delay_min  = 0;
    delay_max  = 2;
    launch(8'h60, 8'd5);
    wait_done("postreset", 300);

    // Random programs, with start pulses injected while busy.
    for (int k = 0; k < 20; k++) begin
      delay_min  = 0;
      delay_max  = int'($urandom_range(0, 3));
      ready_mode = int'($urandom_range(1, 2));
      rpc        = 8'($urandom);
      rlen       = 8'($urandom_range(0, 12));
      launch(rpc, rlen);
      if (rlen > 8'd2 && $urandom_range(0, 1) == 1) begin
        cyc(1);
        start    = 1'b1;
        start_pc = 8'($urandom);
        prog_len = 8'($urandom_range(1, 9));
        cyc(1);
        start = 1'b0;
      end
      wait_done("rand", 400);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
